// File: rtl/dmem_responder.sv
// Byte-addressed data memory answering one core load/store at a time, little-endian.
// Latency: resp_valid rises LATENCY cycles after the accepting edge (LATENCY 1..7).
// Backpressure: req_ready low from accept to response handshake; response held while resp_ready=0.
module dmem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    state_t        state;
    logic [2:0]    cnt;
    resp_t         resp_q;
    resp_t         resp_d;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          acc_vld;
    logic          size_bad;
    logic          align_bad;
    logic          range_bad;
    logic          req_err;
    logic          wr_en;
    logic [2:0]    size_bytes;
    logic [3:0]    byte_en;
    logic [32:0]   end_addr;
    logic [AW-1:0] idx;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   ld_dat;

    // Request decode and legality; range check is done at 33 bits so addresses never wrap.
    always_comb begin
        acc_vld = req_valid && req_ready;
        case (req_size)
            2'b00:   begin size_bytes = 3'd1; byte_en = 4'b0001; end
            2'b01:   begin size_bytes = 3'd2; byte_en = 4'b0011; end
            2'b10:   begin size_bytes = 3'd4; byte_en = 4'b1111; end
            default: begin size_bytes = 3'd4; byte_en = 4'b0000; end
        endcase
        size_bad  = (req_size == 2'b11);
        align_bad = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        end_addr  = {1'b0, req_addr} + {30'd0, size_bytes};
        range_bad = (end_addr > 33'(DEPTH_BYTES));
        req_err   = size_bad || align_bad || range_bad;
        wr_en     = acc_vld && req_write && !req_err;
        idx       = req_addr[AW-1:0];
    end

    // Load path: gather four bytes, then narrow and extend by size.
    always_comb begin
        b0 = mem[idx];
        b1 = mem[idx + AW'(1)];
        b2 = mem[idx + AW'(2)];
        b3 = mem[idx + AW'(3)];
        case (req_size)
            2'b00:   ld_dat = req_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   ld_dat = req_unsigned ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: ld_dat = {b3, b2, b1, b0};
        endcase
        resp_d.err   = req_err;
        resp_d.rdata = (req_write || req_err) ? 32'd0 : ld_dat;
    end

    // Storage has no reset so committed stores survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx + AW'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (acc_vld) begin
                        req_ready <= 1'b0;
                        resp_q    <= resp_d;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_q     <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= 3'd0;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_q     <= '0;
                end
            endcase
        end
    end

    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (LATENCY 2, 1, 7) share one request stream and run in lockstep
// against a byte-array reference model.
module tb_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_valid, req_write, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [2:0]  req_ready, resp_valid, resp_err;
    logic [2:0][31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mm [256];

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) u_dut_l2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    dmem_responder #(.DEPTH_BYTES(256), .LATENCY(7)) u_dut_l7 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid[2]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: legality from byte counts, little-endian bytes, extension by arithmetic mask.
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output logic e, output logic [31:0] rd);
        longint unsigned nb, ea;
        nb = 64'd1 << sz;
        ea = {32'd0, a};
        e  = (sz == 2'd3) || ((ea % nb) != 0) || (ea + nb > 256);
        rd = 32'd0;
        if (!e) begin
            for (int i = 0; i < int'(nb); i++) begin
                if (wr) mm[ea + longint'(i)] = wd[8*i +: 8];
                else    rd = rd | ({24'd0, mm[ea + longint'(i)]} << (8*i));
            end
            if (!wr && !uns && nb < 4 && rd[int'(8*nb) - 1])
                rd = rd | ~((32'd1 << (8*nb)) - 32'd1);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int hold,
                          output logic [31:0] rd0, output logic e0);
        logic        exp_e;
        logic [31:0] exp_rd, held;
        int          lat [3];
        int          n;
        n = 0;
        while (req_ready !== 3'b111 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd7);
        model(wr, a, wd, sz, uns, exp_e, exp_rd);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
        req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        chk("ready_low_busy", 32'(req_ready), 32'd0);
        lat  = '{0, 0, 0};
        held = 32'd0;
        n    = 1;
        forever begin
            for (int d = 0; d < 3; d++)
                if (resp_valid[d] === 1'b1 && lat[d] == 0) lat[d] = n;
            if (lat[0] == n) held = resp_rdata[0];
            if ((lat[0] != 0 && lat[1] != 0 && lat[2] != 0) || n >= 12) break;
            @(negedge clock);
            n++;
        end
        for (int d = 0; d < 3; d++) chk($sformatf("latency_l%0d", lat_of(d)), 32'(lat[d]), 32'(lat_of(d)));
        repeat (hold) @(negedge clock);
        chk("valid_held", 32'(resp_valid), 32'd7);
        chk("ready_low_in_resp", 32'(req_ready), 32'd0);
        chk("rdata_stable", resp_rdata[0], held);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rdata_l%0d", lat_of(d)), resp_rdata[d], exp_rd);
            chk($sformatf("err_l%0d", lat_of(d)), 32'(resp_err[d]), 32'(exp_e));
        end
        rd0 = resp_rdata[0];
        e0  = resp_err[0];
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        chk("valid_low_after_hs", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        e;
        logic [1:0]  sz;
        int          sel;

        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        repeat (3) @(negedge clock);
        chk("rst_ready_held", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("ready_after_release", 32'(req_ready), 32'd7);

        for (int i = 0; i < 256; i += 4) do_txn(1'b1, 32'(i), $urandom(), 2'd2, 1'b0, 0, rd, e);

        // Word round trip and byte layout
        do_txn(1'b1, 32'd100, 32'h00FF01FF, 2'd2, 1'b0, 0, rd, e);
        chk("st100_rdata", rd, 32'd0);
        do_txn(1'b0, 32'd100, 32'd0, 2'd2, 1'b0, 5, rd, e);
        chk("ld100", rd, 32'h00FF01FF);
        do_txn(1'b0, 32'd100, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("b100", rd, 32'h000000FF);
        do_txn(1'b0, 32'd101, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("b101", rd, 32'h00000001);
        do_txn(1'b0, 32'd102, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("b102", rd, 32'h000000FF);
        do_txn(1'b0, 32'd103, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("b103", rd, 32'h00000000);

        // Sign and zero extension
        do_txn(1'b1, 32'd40, 32'h000080FF, 2'd2, 1'b0, 0, rd, e);
        do_txn(1'b0, 32'd41, 32'd0, 2'd0, 1'b0, 0, rd, e); chk("lb41", rd, 32'hFFFFFF80);
        do_txn(1'b0, 32'd41, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("lbu41", rd, 32'h00000080);
        do_txn(1'b0, 32'd40, 32'd0, 2'd1, 1'b0, 0, rd, e); chk("lh40", rd, 32'hFFFF80FF);
        do_txn(1'b0, 32'd40, 32'd0, 2'd1, 1'b1, 0, rd, e); chk("lhu40", rd, 32'h000080FF);

        // Error cases and the top-of-memory boundary
        do_txn(1'b1, 32'd102, 32'hDEADBEEF, 2'd2, 1'b0, 0, rd, e);
        chk("misalign_err", 32'(e), 32'd1); chk("misalign_rdata", rd, 32'd0);
        do_txn(1'b1, 32'd0, 32'hDEADBEEF, 2'd3, 1'b0, 0, rd, e);
        chk("size3_err", 32'(e), 32'd1);
        do_txn(1'b0, 32'd100, 32'd0, 2'd2, 1'b0, 0, rd, e); chk("ld100_intact", rd, 32'h00FF01FF);
        do_txn(1'b1, 32'd252, 32'hA5A55A5A, 2'd2, 1'b0, 0, rd, e); chk("st252_ok", 32'(e), 32'd0);
        do_txn(1'b0, 32'd252, 32'd0, 2'd2, 1'b0, 0, rd, e); chk("ld252", rd, 32'hA5A55A5A);
        do_txn(1'b1, 32'd254, 32'h12345678, 2'd2, 1'b0, 0, rd, e); chk("st254_err", 32'(e), 32'd1);
        do_txn(1'b0, 32'd255, 32'd0, 2'd0, 1'b1, 0, rd, e); chk("lbu255", rd, 32'h000000A5);
        do_txn(1'b0, 32'hFFFFFFFC, 32'd0, 2'd2, 1'b0, 0, rd, e); chk("wrap_err", 32'(e), 32'd1);

        // Reset while a load is in flight; the committed store must survive
        do_txn(1'b1, 32'd0, 32'h00000011, 2'd2, 1'b0, 0, rd, e);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("l2_in_wait", 32'(resp_valid[0]), 32'd0);
        chk("l1_in_resp", 32'(resp_valid[1]), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_drops_valid", 32'(resp_valid), 32'd0);
        chk("rst_drops_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("ready_after_rerelease", 32'(req_ready), 32'd7);
        do_txn(1'b0, 32'd0, 32'd0, 2'd2, 1'b0, 0, rd, e);
        chk("reload0", rd, 32'h00000011);

        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 32'($urandom_range(0, 255));
            else if (sel < 9) a = 32'($urandom_range(248, 263));
            else              a = $urandom();
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_txn(1'($urandom_range(0, 1)), a, $urandom(), sz, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), rd, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
